// File: rtl/logic_axi4_stream_pipeline_pkg.sv
// Shared types and helpers for the AXI4-Stream register-slice pipeline.
// Holds the per-stage state enum and the packed payload width calculation.
package logic_axi4_stream_pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Width of the single vector that carries every stored field through the stages.
    function automatic int payload_width(
        input int tdata_bytes,
        input int tdest_w,
        input int tuser_w,
        input int tid_w,
        input int use_tkeep,
        input int use_tstrb,
        input int use_tlast
    );
        int w;
        w = tdata_bytes * 8 + tdest_w + tuser_w + tid_w;
        if (use_tkeep != 0) w += tdata_bytes;
        if (use_tstrb != 0) w += tdata_bytes;
        if (use_tlast != 0) w += 1;
        return w;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_pipeline_stage.sv
// One full-throughput skid slice: main register plus skid register, registered upstream ready.
// Control flops are reset asynchronously; payload flops are not reset.
module logic_axi4_stream_pipeline_stage
    import logic_axi4_stream_pipeline_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              rdy_q;
    logic [DATA_W-1:0] main_p0;
    logic [DATA_W-1:0] skid_p0;
    logic              in_acc;
    logic              out_acc;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;

    assign in_acc  = in_valid & rdy_q;
    assign out_acc = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_acc) begin
                    state_d   = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                if (in_acc && !out_acc) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (in_acc && out_acc) begin
                    load_main = 1'b1;
                end else if (out_acc) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_acc) begin
                    state_d        = BUSY;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Ready is a flop that looks one cycle ahead, so no tx_tready->rx_tready path exists.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != FULL);
        end
    end

    // Stage boundary: payload registers
    always_ff @(posedge aclk) begin
        if (load_main) main_p0 <= main_from_skid ? skid_p0 : in_data;
        if (load_skid) skid_p0 <= in_data;
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_p0;

endmodule

// File: rtl/logic_axi4_stream_pipeline.sv
// AXI4-Stream pipeline of STAGES cascaded skid slices with flush and occupancy output.
// Define LOGIC_AXI4_STREAM_PIPELINE_OCCUPANCY_EN to build the occupancy counter; otherwise it reads 0.
module logic_axi4_stream_pipeline
    import logic_axi4_stream_pipeline_pkg::*;
#(
    parameter  int STAGES      = 2,
    parameter  int TDATA_BYTES = 4,
    parameter  int TDEST_WIDTH = 1,
    parameter  int TUSER_WIDTH = 1,
    parameter  int TID_WIDTH   = 1,
    parameter  int USE_TKEEP   = 1,
    parameter  int USE_TSTRB   = 1,
    parameter  int USE_TLAST   = 1,
    localparam int OCC_W       = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     flush,
    input  logic                     rx_tvalid,
    output logic                     rx_tready,
    input  logic                     rx_tlast,
    input  logic [TDATA_BYTES*8-1:0] rx_tdata,
    input  logic [TDATA_BYTES-1:0]   rx_tstrb,
    input  logic [TDATA_BYTES-1:0]   rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]   rx_tdest,
    input  logic [TUSER_WIDTH-1:0]   rx_tuser,
    input  logic [TID_WIDTH-1:0]     rx_tid,
    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic                     tx_tlast,
    output logic [TDATA_BYTES*8-1:0] tx_tdata,
    output logic [TDATA_BYTES-1:0]   tx_tstrb,
    output logic [TDATA_BYTES-1:0]   tx_tkeep,
    output logic [TDEST_WIDTH-1:0]   tx_tdest,
    output logic [TUSER_WIDTH-1:0]   tx_tuser,
    output logic [TID_WIDTH-1:0]     tx_tid,
    output logic [OCC_W-1:0]         occupancy
);

    localparam int DATA_W   = TDATA_BYTES * 8;
    localparam int PW       = payload_width(TDATA_BYTES, TDEST_WIDTH, TUSER_WIDTH, TID_WIDTH,
                                            USE_TKEEP, USE_TSTRB, USE_TLAST);
    localparam int KEEP_OFF = DATA_W;
    localparam int STRB_OFF = KEEP_OFF + ((USE_TKEEP != 0) ? TDATA_BYTES : 0);
    localparam int LAST_OFF = STRB_OFF + ((USE_TSTRB != 0) ? TDATA_BYTES : 0);
    localparam int DEST_OFF = LAST_OFF + ((USE_TLAST != 0) ? 1 : 0);
    localparam int USER_OFF = DEST_OFF + TDEST_WIDTH;
    localparam int ID_OFF   = USER_OFF + TUSER_WIDTH;

    if (STAGES == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = flush ^ aclk ^ areset_n;

        assign tx_tvalid = rx_tvalid;
        assign rx_tready = tx_tready;
        assign tx_tdata  = rx_tdata;
        assign tx_tdest  = rx_tdest;
        assign tx_tuser  = rx_tuser;
        assign tx_tid    = rx_tid;
        assign tx_tkeep  = (USE_TKEEP != 0) ? rx_tkeep : '1;
        assign tx_tstrb  = (USE_TSTRB != 0) ? rx_tstrb : '1;
        assign tx_tlast  = (USE_TLAST != 0) ? rx_tlast : 1'b1;
        assign occupancy = '0;
    end else begin : g_pipe
        logic [PW-1:0] rx_pl;
        logic [PW-1:0] tx_pl;
        logic [STAGES:0] vld;
        logic [STAGES:0] rdy;
        logic [PW-1:0] pl [STAGES+1];

        assign rx_pl[0 +: DATA_W]             = rx_tdata;
        assign rx_pl[DEST_OFF +: TDEST_WIDTH] = rx_tdest;
        assign rx_pl[USER_OFF +: TUSER_WIDTH] = rx_tuser;
        assign rx_pl[ID_OFF +: TID_WIDTH]     = rx_tid;
        assign tx_tdata = tx_pl[0 +: DATA_W];
        assign tx_tdest = tx_pl[DEST_OFF +: TDEST_WIDTH];
        assign tx_tuser = tx_pl[USER_OFF +: TUSER_WIDTH];
        assign tx_tid   = tx_pl[ID_OFF +: TID_WIDTH];

        if (USE_TKEEP != 0) begin : g_keep
            assign rx_pl[KEEP_OFF +: TDATA_BYTES] = rx_tkeep;
            assign tx_tkeep = tx_pl[KEEP_OFF +: TDATA_BYTES];
        end else begin : g_nokeep
            logic unused_keep;
            assign unused_keep = ^rx_tkeep;
            assign tx_tkeep    = '1;
        end

        if (USE_TSTRB != 0) begin : g_strb
            assign rx_pl[STRB_OFF +: TDATA_BYTES] = rx_tstrb;
            assign tx_tstrb = tx_pl[STRB_OFF +: TDATA_BYTES];
        end else begin : g_nostrb
            logic unused_strb;
            assign unused_strb = ^rx_tstrb;
            assign tx_tstrb    = '1;
        end

        if (USE_TLAST != 0) begin : g_last
            assign rx_pl[LAST_OFF] = rx_tlast;
            assign tx_tlast        = tx_pl[LAST_OFF];
        end else begin : g_nolast
            logic unused_last;
            assign unused_last = rx_tlast;
            assign tx_tlast    = 1'b1;
        end

        assign vld[0]      = rx_tvalid;
        assign rx_tready   = rdy[0];
        assign pl[0]       = rx_pl;
        assign tx_tvalid   = vld[STAGES];
        assign rdy[STAGES] = tx_tready;
        assign tx_pl       = pl[STAGES];

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            logic_axi4_stream_pipeline_stage #(
                .DATA_W(PW)
            ) u_stage (
                .aclk      (aclk),
                .areset_n  (areset_n),
                .flush     (flush),
                .in_valid  (vld[i]),
                .in_ready  (rdy[i]),
                .in_data   (pl[i]),
                .out_valid (vld[i+1]),
                .out_ready (rdy[i+1]),
                .out_data  (pl[i+1])
            );
        end

`ifdef LOGIC_AXI4_STREAM_PIPELINE_OCCUPANCY_EN
        logic             rx_hs;
        logic             tx_hs;
        logic [OCC_W-1:0] occ_q;

        assign rx_hs = rx_tvalid & rdy[0];
        assign tx_hs = vld[STAGES] & tx_tready;

        // Flush wins over any handshake in the same cycle.
        always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
                occ_q <= '0;
            end else if (flush) begin
                occ_q <= '0;
            end else if (rx_hs && !tx_hs) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (!rx_hs && tx_hs) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end

        assign occupancy = occ_q;
`else
        assign occupancy = '0;
`endif
    end

endmodule

// File: tb/tb_logic_axi4_stream_pipeline.sv
// Bench for logic_axi4_stream_pipeline: three instances (STAGES=2, STAGES=3, STAGES=0 pass-through)
// checked against a queue-based reference model of an ordered, capacity-limited FIFO.
module tb_logic_axi4_stream_pipeline;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b1;
    logic        flush = 1'b0;
    logic        rx_tvalid = 1'b0;
    logic        rx_tlast = 1'b0;
    logic [31:0] rx_tdata = '0;
    logic [3:0]  rx_tstrb = '0;
    logic [3:0]  rx_tkeep = '0;
    logic        rx_tdest = 1'b0;
    logic        rx_tuser = 1'b0;
    logic        rx_tid = 1'b0;
    logic        tx_tready = 1'b0;

    logic        rx_tready2, tx_tvalid2, tx_tlast2, tx_tdest2, tx_tuser2, tx_tid2;
    logic [31:0] tx_tdata2;
    logic [3:0]  tx_tstrb2, tx_tkeep2;
    logic [2:0]  occ2;

    logic        rx_tready3, tx_tvalid3, tx_tlast3, tx_tdest3, tx_tuser3, tx_tid3;
    logic [31:0] tx_tdata3;
    logic [3:0]  tx_tstrb3, tx_tkeep3;
    logic [2:0]  occ3;

    logic        rx_tready0, tx_tvalid0, tx_tlast0, tx_tdest0, tx_tuser0, tx_tid0;
    logic [31:0] tx_tdata0;
    logic [3:0]  tx_tstrb0, tx_tkeep0;
    logic [0:0]  occ0;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    logic_axi4_stream_pipeline #(.STAGES(2)) u_dut2 (
        .aclk(aclk), .areset_n(areset_n), .flush(flush),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready2), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
        .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tid(rx_tid),
        .tx_tvalid(tx_tvalid2), .tx_tready(tx_tready), .tx_tlast(tx_tlast2), .tx_tdata(tx_tdata2),
        .tx_tstrb(tx_tstrb2), .tx_tkeep(tx_tkeep2), .tx_tdest(tx_tdest2), .tx_tuser(tx_tuser2), .tx_tid(tx_tid2),
        .occupancy(occ2)
    );

    logic_axi4_stream_pipeline #(.STAGES(3)) u_dut3 (
        .aclk(aclk), .areset_n(areset_n), .flush(flush),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready3), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
        .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tid(rx_tid),
        .tx_tvalid(tx_tvalid3), .tx_tready(tx_tready), .tx_tlast(tx_tlast3), .tx_tdata(tx_tdata3),
        .tx_tstrb(tx_tstrb3), .tx_tkeep(tx_tkeep3), .tx_tdest(tx_tdest3), .tx_tuser(tx_tuser3), .tx_tid(tx_tid3),
        .occupancy(occ3)
    );

    logic_axi4_stream_pipeline #(.STAGES(0), .USE_TKEEP(0), .USE_TLAST(0)) u_dut0 (
        .aclk(aclk), .areset_n(areset_n), .flush(flush),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready0), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
        .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tid(rx_tid),
        .tx_tvalid(tx_tvalid0), .tx_tready(tx_tready), .tx_tlast(tx_tlast0), .tx_tdata(tx_tdata0),
        .tx_tstrb(tx_tstrb0), .tx_tkeep(tx_tkeep0), .tx_tdest(tx_tdest0), .tx_tuser(tx_tuser0), .tx_tid(tx_tid0),
        .occupancy(occ0)
    );

    // Occupancy the counter should report for n held beats in this build.
    function automatic int occ_exp(input int n);
`ifdef LOGIC_AXI4_STREAM_PIPELINE_OCCUPANCY_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset_n  = 1'b0;
        rx_tvalid = 1'b0;
        flush     = 1'b0;
        tx_tready = 1'b0;
        tick();
        tick();
        areset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 areset_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (rx_tready2 !== 1'b0 || tx_tvalid2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: rx_tready=%b tx_tvalid=%b expected 0 0", rx_tready2, tx_tvalid2);
        end
        n_vec++;
        if (int'(occ2) != 0) begin
            n_err++;
            $display("FAIL reset_occ: got %0d expected 0", occ2);
        end
        areset_n = 1'b1;
        #1;
        n_vec++;
        if (rx_tready2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_early: rx_tready=%b expected 0", rx_tready2);
        end
        tick();
        n_vec++;
        if (rx_tready2 !== 1'b1 || rx_tready3 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_edge: rx_tready2=%b rx_tready3=%b expected 1 1", rx_tready2, rx_tready3);
        end
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 8; i++) begin
            rx_tdata  = $urandom;
            rx_tkeep  = 4'($urandom);
            rx_tstrb  = 4'($urandom);
            rx_tlast  = 1'b0;
            rx_tdest  = 1'($urandom);
            rx_tvalid = 1'($urandom);
            tx_tready = i[0];
            #1;
            n_vec++;
            if (tx_tdata0 !== rx_tdata || tx_tstrb0 !== rx_tstrb || tx_tdest0 !== rx_tdest) begin
                n_err++;
                $display("FAIL pass_payload: got %h/%h/%b expected %h/%h/%b",
                         tx_tdata0, tx_tstrb0, tx_tdest0, rx_tdata, rx_tstrb, rx_tdest);
            end
            n_vec++;
            if (tx_tkeep0 !== 4'hF || tx_tlast0 !== 1'b1) begin
                n_err++;
                $display("FAIL pass_consts: tkeep=%h tlast=%b expected f 1", tx_tkeep0, tx_tlast0);
            end
            n_vec++;
            if (rx_tready0 !== tx_tready || tx_tvalid0 !== rx_tvalid || occ0 !== 1'b0) begin
                n_err++;
                $display("FAIL pass_hs: rx_tready=%b tx_tvalid=%b occ=%b expected %b %b 0",
                         rx_tready0, tx_tvalid0, occ0, tx_tready, rx_tvalid);
            end
        end
    endtask

    task automatic test_latency();
        int rx_cyc [10];
        int sent = 0;
        int got = 0;
        int last_tx = 0;
        do_reset();
        tx_tready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            rx_tvalid = (sent < 10);
            rx_tdata  = 32'(sent);
            #2;
            if (rx_tvalid && rx_tready3) begin
                rx_cyc[sent] = cyc;
                sent++;
            end
            if (tx_tvalid3 && tx_tready) begin
                n_vec++;
                if (tx_tdata3 !== 32'(got)) begin
                    n_err++;
                    $display("FAIL lat_order: got %0d expected %0d", tx_tdata3, got);
                end
                n_vec++;
                if (got < sent && cyc != rx_cyc[got] + 3) begin
                    n_err++;
                    $display("FAIL lat_cycles: beat %0d out at cycle %0d expected %0d", got, cyc, rx_cyc[got] + 3);
                end
                if (got > 0) begin
                    n_vec++;
                    if (cyc != last_tx + 1) begin
                        n_err++;
                        $display("FAIL lat_b2b: beat %0d at cycle %0d expected %0d", got, cyc, last_tx + 1);
                    end
                end
                last_tx = cyc;
                got++;
            end
            tick();
        end
        n_vec++;
        if (got != 10) begin
            n_err++;
            $display("FAIL lat_count: got %0d beats expected 10", got);
        end
        rx_tvalid = 1'b0;
    endtask

    task automatic test_fill();
        int acc = 0;
        int k = 0;
        do_reset();
        tx_tready = 1'b0;
        rx_tvalid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            rx_tdata = 32'(100 + acc);
            #2;
            if (tx_tvalid2) begin
                n_vec++;
                if (tx_tdata2 !== 32'd100) begin
                    n_err++;
                    $display("FAIL fill_stable: got %0d expected 100", tx_tdata2);
                end
            end
            if (rx_tvalid && rx_tready2) acc++;
            tick();
        end
        n_vec++;
        if (acc != 4) begin
            n_err++;
            $display("FAIL fill_count: got %0d accepted expected 4", acc);
        end
        n_vec++;
        if (rx_tready2 !== 1'b0 || int'(occ2) != occ_exp(4)) begin
            n_err++;
            $display("FAIL fill_full: rx_tready=%b occ=%0d expected 0 %0d", rx_tready2, occ2, occ_exp(4));
        end
        rx_tvalid = 1'b0;
        tx_tready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #2;
            if (tx_tvalid2) begin
                n_vec++;
                if (tx_tdata2 !== 32'(100 + k)) begin
                    n_err++;
                    $display("FAIL drain_order: got %0d expected %0d", tx_tdata2, 100 + k);
                end
                k++;
            end
            tick();
        end
        n_vec++;
        if (k != 4 || int'(occ2) != 0) begin
            n_err++;
            $display("FAIL drain_count: got %0d beats occ %0d expected 4 0", k, occ2);
        end
    endtask

    task automatic test_flush();
        int acc = 0;
        int k = 0;
        do_reset();
        tx_tready = 1'b0;
        for (int cyc = 0; cyc < 10 && acc < 3; cyc++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = 32'(200 + acc);
            #2;
            if (rx_tready2) acc++;
            tick();
        end
        rx_tvalid = 1'b1;
        rx_tdata  = 32'hDEAD_BEEF;
        flush     = 1'b1;
        #1;
        n_vec++;
        if (rx_tready2 !== 1'b1 || int'(occ2) != occ_exp(3)) begin
            n_err++;
            $display("FAIL flush_pre: rx_tready=%b occ=%0d expected 1 %0d", rx_tready2, occ2, occ_exp(3));
        end
        tick();
        flush     = 1'b0;
        rx_tvalid = 1'b0;
        n_vec++;
        if (tx_tvalid2 !== 1'b0 || int'(occ2) != 0 || rx_tready2 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_post: tx_tvalid=%b occ=%0d rx_tready=%b expected 0 0 1",
                     tx_tvalid2, occ2, rx_tready2);
        end
        tx_tready = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rx_tvalid = (acc < 2);
            rx_tdata  = 32'(300 + acc);
            #2;
            if (rx_tvalid && rx_tready2) acc++;
            if (tx_tvalid2) begin
                n_vec++;
                if (tx_tdata2 !== 32'(300 + k)) begin
                    n_err++;
                    $display("FAIL flush_after: got %h expected %h", tx_tdata2, 32'(300 + k));
                end
                k++;
            end
            tick();
        end
        rx_tvalid = 1'b0;
        n_vec++;
        if (k != 2) begin
            n_err++;
            $display("FAIL flush_after_count: got %0d beats expected 2", k);
        end
    endtask

    task automatic test_async_reset();
        int acc = 0;
        do_reset();
        tx_tready = 1'b0;
        for (int cyc = 0; cyc < 10 && acc < 2; cyc++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = 32'(400 + acc);
            #2;
            if (rx_tready2) acc++;
            tick();
        end
        rx_tvalid = 1'b0;
        n_vec++;
        if (tx_tvalid2 !== 1'b1 || int'(occ2) != occ_exp(2)) begin
            n_err++;
            $display("FAIL arst_pre: tx_tvalid=%b occ=%0d expected 1 %0d", tx_tvalid2, occ2, occ_exp(2));
        end
        #2 areset_n = 1'b0;
        #1;
        n_vec++;
        if (tx_tvalid2 !== 1'b0 || rx_tready2 !== 1'b0 || int'(occ2) != 0) begin
            n_err++;
            $display("FAIL arst_async: tx_tvalid=%b rx_tready=%b occ=%0d expected 0 0 0",
                     tx_tvalid2, rx_tready2, occ2);
        end
        tick();
        tick();
        areset_n = 1'b1;
        #1;
        n_vec++;
        if (rx_tready2 !== 1'b0) begin
            n_err++;
            $display("FAIL arst_release_early: rx_tready=%b expected 0", rx_tready2);
        end
        tick();
        n_vec++;
        if (rx_tready2 !== 1'b1 || tx_tvalid2 !== 1'b0) begin
            n_err++;
            $display("FAIL arst_release: rx_tready=%b tx_tvalid=%b expected 1 0", rx_tready2, tx_tvalid2);
        end
    endtask

    task automatic test_random();
        logic [43:0] exp_q [$];
        logic [43:0] exp_v;
        logic [43:0] tx_v;
        logic [43:0] prev_v = '0;
        logic        prev_stall = 1'b0;
        logic        last_rx_hs = 1'b0;
        int sent = 0;
        int got = 0;
        do_reset();
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            if (!rx_tvalid || last_rx_hs) begin
                rx_tvalid = (sent < 1000) && ($urandom_range(1, 0) == 1);
                rx_tdata  = $urandom;
                rx_tkeep  = 4'($urandom);
                rx_tstrb  = 4'($urandom);
                rx_tlast  = 1'($urandom);
                rx_tdest  = 1'($urandom);
                rx_tuser  = 1'($urandom);
                rx_tid    = 1'($urandom);
            end
            tx_tready = 1'($urandom);
            #2;
            tx_v = {tx_tid2, tx_tuser2, tx_tdest2, tx_tlast2, tx_tstrb2, tx_tkeep2, tx_tdata2};
            n_vec++;
            if (int'(occ2) != occ_exp(exp_q.size())) begin
                n_err++;
                $display("FAIL rnd_occ: got %0d expected %0d", occ2, occ_exp(exp_q.size()));
            end
            if (prev_stall) begin
                n_vec++;
                if (tx_tvalid2 !== 1'b1 || tx_v !== prev_v) begin
                    n_err++;
                    $display("FAIL rnd_stable: valid=%b beat=%h expected 1 %h", tx_tvalid2, tx_v, prev_v);
                end
            end
            last_rx_hs = rx_tvalid && rx_tready2;
            if (last_rx_hs) begin
                exp_q.push_back({rx_tid, rx_tuser, rx_tdest, rx_tlast, rx_tstrb, rx_tkeep, rx_tdata});
                sent++;
            end
            if (tx_tvalid2 && tx_tready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_extra: got beat %h expected none", tx_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (tx_v !== exp_v) begin
                        n_err++;
                        $display("FAIL rnd_beat: got %h expected %h", tx_v, exp_v);
                    end
                end
                got++;
            end
            n_vec++;
            if (exp_q.size() > 4) begin
                n_err++;
                $display("FAIL rnd_capacity: held %0d expected at most 4", exp_q.size());
            end
            prev_stall = tx_tvalid2 && !tx_tready;
            prev_v     = tx_v;
            tick();
        end
        rx_tvalid = 1'b0;
        n_vec++;
        if (got != 1000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rnd_total: got %0d beats with %0d left expected 1000 0", got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_latency();
        test_fill();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/logic_axi4_stream_pipeline.md
LOGIC_AXI4_STREAM_PIPELINE -- requirements
Module: logic_axi4_stream_pipeline

Interface
REQ-001 Parameter STAGES, default 2: number of cascaded register-slice stages; legal range 0..16.
REQ-002 Parameters TDATA_BYTES 4, TDEST_WIDTH 1, TUSER_WIDTH 1, TID_WIDTH 1: sideband widths.
REQ-003 Parameters USE_TKEEP 1, USE_TSTRB 1, USE_TLAST 1: when 0, the field is not stored; tx_tkeep/tx_tstrb drive all-ones and tx_tlast drives 1.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: aclk in 1 (clock); areset_n in 1 (reset).
REQ-005 Ports rx_tvalid in 1; rx_tready out 1; rx_tlast in 1; rx_tdata in TDATA_BYTES x 8; rx_tstrb and rx_tkeep in TDATA_BYTES; rx_tdest in TDEST_WIDTH; rx_tuser in TUSER_WIDTH; rx_tid in TID_WIDTH.
REQ-006 Ports tx_* SHALL mirror rx_* with opposite directions: tx_tready in, all other tx_* out.
REQ-007 Port flush in 1: synchronous discard of all held beats.
REQ-008 Port occupancy out clog2(2*STAGES+1): number of beats currently held.

Function
REQ-009 Each stage SHALL be a full-throughput skid slice: main register plus one skid register, capacity 2 beats; total capacity 2*STAGES.
REQ-010 rx_tready SHALL be driven from a register only; no combinational path from tx_tready to rx_tready for STAGES>=1.
REQ-011 A beat is transferred when valid and ready are both high on a rising aclk edge; ready is not required to precede valid.
REQ-012 With tx_tready held 1, latency rx to tx SHALL be exactly STAGES cycles, at 1 beat/cycle sustained.
REQ-013 Beat order and every payload field SHALL be preserved bit-exactly.
REQ-014 Once tx_tvalid is 1, it and all tx payload SHALL stay stable until the tx handshake completes (AXI4-Stream rule).
REQ-015 Stage states: EMPTY (main invalid) -> BUSY (main valid) on input accept; BUSY -> FULL (skid valid, upstream ready dropped) on input while downstream stalled; FULL -> BUSY on downstream accept (skid moves to main); BUSY -> EMPTY on downstream accept without input.
REQ-016 Simultaneous accept and emit in BUSY SHALL keep BUSY and hold throughput; FULL never accepts input.
REQ-017 occupancy SHALL be updated each cycle as +1 on rx handshake, -1 on tx handshake, unchanged on both; it never exceeds 2*STAGES nor goes below 0.
REQ-018 flush=1 SHALL clear all stages: next cycle tx_tvalid=0, occupancy=0, rx_tready=1; any rx beat accepted in the flush cycle is discarded; flush has priority over all handshakes.
REQ-019 STAGES=0 SHALL be a pure wire connection rx<->tx; flush ignored; occupancy fixed 0.

Reset
REQ-020 While areset_n=0: tx_tvalid=0, rx_tready=0, occupancy=0; all stage states EMPTY.
REQ-021 rx_tready SHALL rise on the first aclk edge after areset_n deassertion.
REQ-022 Payload registers SHALL NOT be reset; only valid/ready/state/counter flops are reset.
REQ-023 Reset asserted mid-transfer SHALL drop all held beats immediately and asynchronously.

Configuration
REQ-024 Macro LOGIC_AXI4_STREAM_PIPELINE_OCCUPANCY_EN: when defined, the occupancy counter is implemented per REQ-017; when undefined, the counter logic is omitted and occupancy drives constant 0.

Structure
REQ-025 Package logic_axi4_stream_pipeline_pkg SHALL hold the stage-state enum (EMPTY, BUSY, FULL) and a function computing the packed payload width from the USE_* and width parameters.
REQ-026 Payload SHALL be packed into one vector and carried through STAGES instances of sub-module logic_axi4_stream_pipeline_stage via a generate loop.

Verification
REQ-027 STAGES=3, tx_tready=1, 10 beats tdata 0..9 back-to-back -> tdata 0 appears on tx exactly 3 cycles after accept, 10 consecutive tx beats, in order.
REQ-028 STAGES=2, tx_tready=0, rx_tvalid=1 continuously -> exactly 4 beats accepted, then rx_tready=0 and occupancy=4; tx payload stable throughout.
REQ-029 STAGES=2, random 50% valid and 50% ready, 1000 beats with random tkeep/tlast/tdest -> scoreboard match, no loss or duplication, no stability violation.
REQ-030 Occupancy 3, flush pulsed with simultaneous rx beat -> next cycle tx_tvalid=0, occupancy=0, the flushed-cycle beat never appears on tx.
REQ-031 areset_n dropped with occupancy 2 -> tx_tvalid, rx_tready, occupancy 0 before next edge; rx_tready=1 one edge after release.
REQ-032 USE_TLAST=0, USE_TKEEP=0, STAGES=0 -> tx_tlast=1, tx_tkeep all-ones, tx_tready reflected on rx_tready in the same cycle.
